halton3_digit_decoder: RTL

- Reader side of the base-3 Halton digit counter chain.
- Accepts one snapshot of the ternary digit vector (digit 0 = least-significant counter digit) and converts it to the scaled radical-inverse integer, sum d_i * 3^(DIGITS-1-i), by serial Horner accumulation.
- Sits between the Halton digit counters and the binary comparators of the stochastic-number generator.
- Valid/ready on both sides.

---
 rtl/halton3_pkg.sv | 26 ++
 rtl/halton3_digit_decoder_if.sv | 42 ++++
 rtl/halton3_horner_step.sv | 22 ++
 rtl/halton3_digit_decoder.sv | 120 ++++++++++++
 4 files changed

// File: rtl/halton3_pkg.sv
// Shared definitions for the base-3 Halton digit chain: radix constants, digit type,
// decoder FSM states and a small power-of-three helper.
package halton3_pkg;

    localparam int BASE    = 3;
    localparam int LOGBASE = 2;

    typedef logic [LOGBASE-1:0] digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dec_state_t;

    // Smallest output width that holds every radical-inverse value for a digit count.
    function automatic int min_outw(input int digits);
        longint p;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            p = p * BASE;
        end
        return $clog2(p);
    endfunction

endpackage

// File: rtl/halton3_digit_decoder_if.sv
// Valid/ready bundle between the digit counters, the decoder and the comparators.
// out_err exists only when HALTON3_DEC_ERR_EN is defined.
interface halton3_digit_decoder_if
    import halton3_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int OUTW   = 7
);

    logic                        in_valid;
    logic                        in_ready;
    logic [DIGITS*LOGBASE-1:0]   in_digits;
    logic                        out_valid;
    logic                        out_ready;
    logic [OUTW-1:0]             out_data;
`ifdef HALTON3_DEC_ERR_EN
    logic                        out_err;
`endif

`ifdef HALTON3_DEC_ERR_EN
    modport master (
        output in_valid, in_digits, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_digits, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
`else
    modport master (
        output in_valid, in_digits, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_digits, out_ready,
        output in_ready, out_valid, out_data
    );
`endif

endinterface

// File: rtl/halton3_horner_step.sv
// One Horner step of the base-3 radical inverse: acc_out = acc_in*3 + digit (mod 2^OUTW).
// A set mask makes the digit contribute zero.
module halton3_horner_step
    import halton3_pkg::*;
#(
    parameter int OUTW = 7
) (
    input  logic [OUTW-1:0] acc_in,
    input  digit_t          digit,
    input  logic            mask,
    output logic [OUTW-1:0] acc_out
);

    logic [OUTW-1:0] term;

    // Times-three as shift-plus-add keeps the datapath to two adders.
    always_comb begin
        term    = mask ? '0 : OUTW'(digit);
        acc_out = (acc_in << 1) + acc_in + term;
    end

endmodule

// File: rtl/halton3_digit_decoder.sv
// Serial Horner decoder: one ternary digit snapshot in, scaled radical-inverse integer out.
// Define HALTON3_DEC_ERR_EN to flag and zero illegal digit code 3 (adds out_err).
module halton3_digit_decoder
    import halton3_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int OUTW   = 7
) (
    input logic clk,
    input logic rst_n,
    halton3_digit_decoder_if.slave bus
);

    localparam int              IDXW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IX = IDXW'(DIGITS - 1);

    dec_state_t               state;
    dec_state_t               state_nx;
    logic [OUTW-1:0]          acc;
    logic [OUTW-1:0]          acc_step;
    logic [IDXW-1:0]          idx;
    digit_t [DIGITS-1:0]      digits;
    digit_t                   cur;
    logic                     mask;
    logic                     accept;
    logic                     step;
`ifdef HALTON3_DEC_ERR_EN
    logic                     err;
`endif

    // Digit 0 is consumed first so it lands on the highest power of three.
    assign cur = digits[idx];

`ifdef HALTON3_DEC_ERR_EN
    assign mask = (cur == digit_t'(BASE));
`else
    assign mask = 1'b0;
`endif

    halton3_horner_step #(
        .OUTW (OUTW)
    ) u_step (
        .acc_in  (acc),
        .digit   (cur),
        .mask    (mask),
        .acc_out (acc_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        accept        = 1'b0;
        step          = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept   = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (idx == LAST_IX) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // The digit snapshot is taken only at the accept edge; later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            idx    <= '0;
            digits <= '0;
`ifdef HALTON3_DEC_ERR_EN
            err    <= 1'b0;
`endif
        end else if (accept) begin
            acc    <= '0;
            idx    <= '0;
            digits <= bus.in_digits;
`ifdef HALTON3_DEC_ERR_EN
            err    <= 1'b0;
`endif
        end else if (step) begin
            acc    <= acc_step;
            idx    <= idx + 1'b1;
`ifdef HALTON3_DEC_ERR_EN
            err    <= err | mask;
`endif
        end
    end

    assign bus.out_data = acc;

`ifdef HALTON3_DEC_ERR_EN
    assign bus.out_err = err & (state == DONE);
`endif

endmodule
